kv_ttl_store: RTL

KV_TTL_STORE -- requirements
Module: kv_ttl_store

---
 rtl/kv_ttl_store.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/kv_ttl_store.sv
// Key/value store with per-entry TTL, IDLE/EXEC/RESP handshake; response valid two cycles after the request is driven.
// req_ready only in IDLE; a response is held stable until rsp_ready, stalling new requests.
module kv_ttl_store #(
   parameter int NUM_ENTRIES   = 16,
   parameter int KEY_WIDTH     = 16,
   parameter int VALUE_WIDTH   = 64,
   parameter int TTL_WIDTH     = 16,
   parameter bit EVICT_ON_FULL = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [1:0]             req_op,
   input  logic [KEY_WIDTH-1:0]   req_key,
   input  logic [VALUE_WIDTH-1:0] req_value,
   input  logic [TTL_WIDTH-1:0]   req_ttl,
   input  logic                   tick,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [1:0]             rsp_status,
   output logic [VALUE_WIDTH-1:0] rsp_value,
   output logic [NUM_ENTRIES-1:0] rsp_index,
   output logic [NUM_ENTRIES-1:0] used_entries
);

   localparam int IW = $clog2(NUM_ENTRIES);
   localparam logic [1:0] OP_GET = 2'b00, OP_PUT = 2'b01, OP_DEL = 2'b10;
   localparam logic [1:0] ST_OK = 2'b00, ST_MISS = 2'b01, ST_FULL = 2'b10, ST_BADKEY = 2'b11;
   localparam logic [NUM_ENTRIES-1:0] ONE_HOT0 = NUM_ENTRIES'(1);
   localparam logic [TTL_WIDTH-1:0] TTL_ONE = TTL_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t                 state_q;
   logic [1:0]             op_q;
   logic [KEY_WIDTH-1:0]   key_q;
   logic [VALUE_WIDTH-1:0] val_q;
   logic [TTL_WIDTH-1:0]   ttl_q;
   logic [KEY_WIDTH-1:0]   keys_q [NUM_ENTRIES];
   logic [VALUE_WIDTH-1:0] vals_q [NUM_ENTRIES];
   logic [TTL_WIDTH-1:0]   ttls_q [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] used_q;
   logic [IW-1:0]          vptr_q;
   logic [1:0]             rsp_status_q;
   logic [VALUE_WIDTH-1:0] rsp_value_q;
   logic [NUM_ENTRIES-1:0] rsp_index_q;

   logic          hit_any, free_any, put_en, put_evict;
   logic [IW-1:0] hit_idx, free_idx, put_idx, vptr_d;

   // Descending scan leaves the lowest matching / free index.
   always_comb begin
      hit_any  = 1'b0;
      hit_idx  = '0;
      free_any = 1'b0;
      free_idx = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (used_q[i] && keys_q[i] == key_q) begin
            hit_any = 1'b1;
            hit_idx = IW'(i);
         end
         if (!used_q[i]) begin
            free_any = 1'b1;
            free_idx = IW'(i);
         end
      end
   end

   assign put_evict = !hit_any && !free_any;
   assign put_en    = hit_any || free_any || EVICT_ON_FULL;
   assign put_idx   = hit_any ? hit_idx : (free_any ? free_idx : vptr_q);
   assign vptr_d    = (vptr_q == IW'(NUM_ENTRIES - 1)) ? '0 : vptr_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         op_q         <= '0;
         key_q        <= '0;
         val_q        <= '0;
         ttl_q        <= '0;
         used_q       <= '0;
         vptr_q       <= '0;
         rsp_status_q <= ST_OK;
         rsp_value_q  <= '0;
         rsp_index_q  <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            keys_q[i] <= '0;
            vals_q[i] <= '0;
            ttls_q[i] <= '0;
         end
      end else begin
         // Ageing first; EXEC writes below are later assignments and take priority.
         if (tick) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
               if (used_q[i]) begin
                  if (ttls_q[i] == TTL_ONE)
                     used_q[i] <= 1'b0;
                  else if (ttls_q[i] > TTL_ONE)
                     ttls_q[i] <= ttls_q[i] - TTL_ONE;
               end
            end
         end
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  op_q    <= req_op;
                  key_q   <= req_key;
                  val_q   <= req_value;
                  ttl_q   <= req_ttl;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               state_q      <= RESP;
               rsp_status_q <= ST_OK;
               rsp_value_q  <= '0;
               rsp_index_q  <= '0;
               if (op_q != 2'b11 && key_q == '0) begin
                  rsp_status_q <= ST_BADKEY;
               end else begin
                  case (op_q)
                     OP_GET: begin
                        if (hit_any) begin
                           rsp_value_q <= vals_q[hit_idx];
                           rsp_index_q <= ONE_HOT0 << hit_idx;
                        end else begin
                           rsp_status_q <= ST_MISS;
                        end
                     end
                     OP_PUT: begin
                        if (put_en) begin
                           keys_q[put_idx] <= key_q;
                           vals_q[put_idx] <= val_q;
                           ttls_q[put_idx] <= ttl_q;
                           used_q[put_idx] <= 1'b1;
                           rsp_index_q     <= ONE_HOT0 << put_idx;
                           if (put_evict)
                              vptr_q <= vptr_d;
                        end else begin
                           rsp_status_q <= ST_FULL;
                        end
                     end
                     OP_DEL: begin
                        if (hit_any) begin
                           used_q[hit_idx] <= 1'b0;
                           rsp_index_q     <= ONE_HOT0 << hit_idx;
                        end else begin
                           rsp_status_q <= ST_MISS;
                        end
                     end
                     default: used_q <= '0;
                  endcase
               end
            end
            RESP: begin
               if (rsp_ready)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready    = (state_q == IDLE);
   assign rsp_valid    = (state_q == RESP);
   assign rsp_status   = rsp_status_q;
   assign rsp_value    = rsp_value_q;
   assign rsp_index    = rsp_index_q;
   assign used_entries = used_q;

endmodule
